bk_sd_sequencer: RTL and testbench

Sector sequencer that streams cartridge save RAM between the SD image and the cart RAM backup port (`bk_*`). It generates the host block requests (`sd_lba`/`sd_rd`/`sd_wr`), steps through every sector the cartridge header requires, and routes host buffer traffic onto `bk_addr`/`bk_data`/`bk_wr`/`bk_rtc_wr`. On save it returns `bk_q` to the host. It sits in the top level between the host I/O block and `cart_top`'s backup port.

---
 rtl/bk_sd_sequencer_pkg.sv | 31 +++
 rtl/bk_sd_sequencer_req_edge.sv | 21 ++
 rtl/bk_sd_sequencer.sv | 148 ++++++++++++++
 tb/tb_bk_sd_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_sd_sequencer_pkg.sv
// Shared types and sizes for the save-RAM sector sequencer.
package bk_sd_sequencer_pkg;

  localparam int unsigned SECTOR_W         = 9;
  localparam int unsigned WORDS_PER_SECTOR = 256;
  localparam int unsigned BUFF_ADDR_W      = $clog2(WORDS_PER_SECTOR);
  localparam int unsigned BK_ADDR_W        = SECTOR_W + BUFF_ADDR_W;
  localparam int unsigned DATA_W           = 16;
  localparam int unsigned LBA_W            = 32;
  localparam int unsigned MASK_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Index of the final sector: the last RAM sector, plus one when an RTC sector follows.
  function automatic logic [SECTOR_W-1:0] last_sector(input logic [MASK_W-1:0] mask,
                                                     input logic              rtc);
    return {1'b0, mask} + SECTOR_W'(rtc);
  endfunction

  // Sector number that carries the RTC words when an RTC is present.
  function automatic logic [SECTOR_W-1:0] rtc_sector_idx(input logic [MASK_W-1:0] mask);
    return {1'b0, mask} + SECTOR_W'(1);
  endfunction

endpackage

// File: rtl/bk_sd_sequencer_req_edge.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a 0->1 input transition.
module bk_sd_sequencer_req_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/bk_sd_sequencer.sv
// Streams cartridge save RAM (and an optional RTC sector) between the SD image and the
// cart backup port, one 512-byte sector per host block request.
module bk_sd_sequencer
  import bk_sd_sequencer_pkg::*;
(
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   bk_load,
  input  logic                   bk_save,
  input  logic                   bk_abort,
  input  logic [MASK_W-1:0]      ram_mask_file,
  input  logic                   has_rtc,
  output logic [LBA_W-1:0]       sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  input  logic [BUFF_ADDR_W-1:0] sd_buff_addr,
  input  logic [DATA_W-1:0]      sd_buff_dout,
  input  logic                   sd_buff_wr,
  output logic [DATA_W-1:0]      sd_buff_din,
  output logic [BK_ADDR_W-1:0]   bk_addr,
  output logic [DATA_W-1:0]      bk_data,
  output logic                   bk_wr,
  output logic                   bk_rtc_wr,
  input  logic [DATA_W-1:0]      bk_q,
  input  logic [DATA_W-1:0]      rtc_q,
  output logic                   bk_busy,
  output logic                   bk_done
);

  state_t              state;
  state_t              state_next;
  logic                dir;
  logic                dir_next;
  logic [SECTOR_W-1:0] sector;
  logic [SECTOR_W-1:0] sector_next;
  logic                load_pulse;
  logic                save_pulse;
  logic                rtc_sector;
  logic                rtc_sel_q;
  logic [DATA_W-1:0]   rtc_word_q;

  bk_sd_sequencer_req_edge u_load_edge (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .level (bk_load),
    .pulse (load_pulse)
  );

  bk_sd_sequencer_req_edge u_save_edge (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .level (bk_save),
    .pulse (save_pulse)
  );

  assign rtc_sector = has_rtc & (sector == rtc_sector_idx(ram_mask_file));

  // State, direction and sector registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      dir    <= 1'b0;
      sector <= '0;
    end else begin
      state  <= state_next;
      dir    <= dir_next;
      sector <= sector_next;
    end
  end

  // Next state; abort overrides everything, load wins over a simultaneous save.
  always_comb begin
    state_next  = state;
    dir_next    = dir;
    sector_next = sector;
    if (bk_abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_pulse | save_pulse) begin
            dir_next    = ~load_pulse;
            sector_next = '0;
            state_next  = ST_REQ;
          end
        end
        ST_REQ:  if (sd_ack)  state_next = ST_XFER;
        ST_XFER: if (!sd_ack) state_next = ST_NEXT;
        ST_NEXT: begin
          if (sector == last_sector(ram_mask_file, has_rtc)) begin
            state_next = ST_DONE;
          end else begin
            sector_next = sector + SECTOR_W'(1);
            state_next  = ST_REQ;
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // The RTC word is combinational on the address, so delay it to line up with bk_q.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rtc_sel_q  <= 1'b0;
      rtc_word_q <= '0;
    end else begin
      rtc_sel_q  <= rtc_sector;
      rtc_word_q <= rtc_q;
    end
  end

  // Outputs; the buffer-side paths are forced to zero while reset is held.
  always_comb begin
    sd_rd       = 1'b0;
    sd_wr       = 1'b0;
    bk_wr       = 1'b0;
    bk_rtc_wr   = 1'b0;
    bk_done     = 1'b0;
    bk_busy     = (state != ST_IDLE);
    sd_lba      = LBA_W'(sector);
    bk_addr     = '0;
    bk_data     = '0;
    sd_buff_din = '0;
    if (reset_n) begin
      bk_addr     = {sector, sd_buff_addr};
      bk_data     = sd_buff_dout;
      sd_buff_din = rtc_sel_q ? rtc_word_q : bk_q;
    end
    case (state)
      ST_REQ: begin
        sd_rd = ~dir;
        sd_wr = dir;
      end
      ST_XFER: begin
        if (!dir && sd_ack && sd_buff_wr && !bk_abort) begin
          bk_wr     = ~rtc_sector;
          bk_rtc_wr = rtc_sector;
        end
      end
      ST_DONE: bk_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bk_sd_sequencer.sv
// Self-checking bench for bk_sd_sequencer: host model, backup RAM/RTC model and a reference image.
module tb_bk_sd_sequencer;

  localparam int RAM_WORDS = 131072;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        bk_load, bk_save, bk_abort, has_rtc;
  logic [7:0]  ram_mask_file;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout, sd_buff_din, bk_data, rtc_q;
  logic [15:0] bk_q = 16'h0;
  logic [16:0] bk_addr;
  logic        bk_wr, bk_rtc_wr, bk_busy, bk_done;

  logic [15:0] ram     [RAM_WORDS];
  logic [15:0] ref_ram [RAM_WORDS];
  logic [15:0] rtc_mem [4];
  logic [15:0] rtc_ref [4];
  logic        mem_ready = 1'b0;
  logic [15:0] salt;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wr_cnt = 0;

  always #5 clk_sys = ~clk_sys;

  bk_sd_sequencer dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .bk_load       (bk_load),
    .bk_save       (bk_save),
    .bk_abort      (bk_abort),
    .ram_mask_file (ram_mask_file),
    .has_rtc       (has_rtc),
    .sd_lba        (sd_lba),
    .sd_rd         (sd_rd),
    .sd_wr         (sd_wr),
    .sd_ack        (sd_ack),
    .sd_buff_addr  (sd_buff_addr),
    .sd_buff_dout  (sd_buff_dout),
    .sd_buff_wr    (sd_buff_wr),
    .sd_buff_din   (sd_buff_din),
    .bk_addr       (bk_addr),
    .bk_data       (bk_data),
    .bk_wr         (bk_wr),
    .bk_rtc_wr     (bk_rtc_wr),
    .bk_q          (bk_q),
    .rtc_q         (rtc_q),
    .bk_busy       (bk_busy),
    .bk_done       (bk_done)
  );

  function automatic logic [15:0] init_word(input int i);
    return 16'((i * 40503) ^ (i >> 5)) ^ salt;
  endfunction

  // Cart backup RAM (1-cycle read latency) and RTC register file.
  always @(posedge clk_sys) begin
    if (!mem_ready) begin
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= init_word(i);
      for (int k = 0; k < 4; k++) rtc_mem[k] <= init_word(RAM_WORDS + k);
      mem_ready <= 1'b1;
    end else begin
      if (bk_wr) ram[bk_addr] <= bk_data;
      if (bk_rtc_wr) rtc_mem[bk_addr[1:0]] <= bk_data;
      bk_q <= ram[bk_addr];
    end
    if (bk_done) done_cnt <= done_cnt + 1;
    if (bk_wr) wr_cnt <= wr_cnt + 1;
  end
  assign rtc_q = rtc_mem[bk_addr[1:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_images(input string tag);
    int bad = 0;
    for (int i = 0; i < RAM_WORDS; i++) if (ram[i] !== ref_ram[i]) bad++;
    check(tag, 32'(bad), 32'd0);
    for (int k = 0; k < 4; k++) check("rtc_word", 32'(rtc_mem[k]), 32'(rtc_ref[k]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lba"}, sd_lba, 32'd0);
    check({tag, "_rdwr"}, 32'({sd_rd, sd_wr}), 32'd0);
    check({tag, "_din"}, 32'(sd_buff_din), 32'd0);
    check({tag, "_addr"}, 32'(bk_addr), 32'd0);
    check({tag, "_data"}, 32'(bk_data), 32'd0);
    check({tag, "_wr"}, 32'({bk_wr, bk_rtc_wr}), 32'd0);
    check({tag, "_busy_done"}, 32'({bk_busy, bk_done}), 32'd0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!(sd_rd || sd_wr) && n < 64) begin
      @(negedge clk_sys);
      n++;
    end
    check("req_seen", 32'(sd_rd | sd_wr), 32'd1);
  endtask

  // Host side of one sector: check the request, ack it, move nwords, release.
  task automatic serve_sector(input int s, input bit save, input int mask, input bit rtc,
                              input int nwords, input bit last);
    bit          rtc_sec;
    logic [16:0] exp_addr;
    logic [15:0] d;
    logic [15:0] exp_d;
    rtc_sec = rtc && (s == mask + 1);
    wait_req();
    check("req_lba", sd_lba, 32'(s));
    check("req_wr", 32'(sd_wr), 32'(save));
    check("req_rd", 32'(sd_rd), 32'(!save));
    repeat ($urandom_range(0, 2)) @(negedge clk_sys);
    check("req_hold", 32'(sd_rd | sd_wr), 32'd1);
    @(posedge clk_sys); #1 sd_ack = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("req_drop", 32'(sd_rd | sd_wr), 32'd0);
    for (int a = 0; a < nwords; a++) begin
      exp_addr = {9'(s), 8'(a)};
      if (save) begin
        @(posedge clk_sys); #1 sd_buff_addr = 8'(a);
        @(posedge clk_sys); #1;
        @(negedge clk_sys);
        exp_d = rtc_sec ? rtc_ref[a % 4] : ref_ram[exp_addr];
        check("save_din", 32'(sd_buff_din), 32'(exp_d));
      end else begin
        d = 16'(a ^ s);
        @(posedge clk_sys); #1 sd_buff_addr = 8'(a); sd_buff_dout = d; sd_buff_wr = 1'b1;
        @(negedge clk_sys);
        check("load_addr", 32'(bk_addr), 32'(exp_addr));
        check("load_data", 32'(bk_data), 32'(d));
        check("load_wr", 32'(bk_wr), 32'(!rtc_sec));
        check("load_rtc_wr", 32'(bk_rtc_wr), 32'(rtc_sec));
        if (rtc_sec) rtc_ref[a % 4] = d;
        else ref_ram[exp_addr] = d;
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk_sys); #1 sd_buff_wr = 1'b0;
          @(negedge clk_sys);
          check("gap_wr", 32'(bk_wr | bk_rtc_wr), 32'd0);
        end
      end
    end
    @(posedge clk_sys); #1 sd_ack = 1'b0; sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("next_gap", 32'(sd_rd | sd_wr), 32'd0);
    @(negedge clk_sys);
    if (last) begin
      check("done_pulse", 32'({bk_done, bk_busy}), 32'd3);
      @(negedge clk_sys);
      check("idle_after", 32'({bk_done, bk_busy}), 32'd0);
    end else begin
      check("rereq", 32'(sd_rd | sd_wr), 32'd1);
    end
  endtask

  task automatic start_transfer(input bit save, input int mask, input bit rtc);
    ram_mask_file = 8'(mask);
    has_rtc = rtc;
    @(posedge clk_sys); #1 if (save) bk_save = 1'b1; else bk_load = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("start_wait", 32'(bk_busy), 32'd0);
    @(negedge clk_sys);
    check("start_req", 32'(save ? sd_wr : sd_rd), 32'd1);
    bk_save = 1'b0;
    bk_load = 1'b0;
  endtask

  task automatic run_transfer(input bit save, input int mask, input bit rtc, input int nwords);
    int total = mask + 1 + int'(rtc);
    int d0 = done_cnt;
    start_transfer(save, mask, rtc);
    for (int s = 0; s < total; s++) serve_sector(s, save, mask, rtc, nwords, s == total - 1);
    check("done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int wc;
    salt = 16'($urandom);
    for (int i = 0; i < RAM_WORDS; i++) ref_ram[i] = init_word(i);
    for (int k = 0; k < 4; k++) rtc_ref[k] = init_word(RAM_WORDS + k);
    reset_n = 1'b0; bk_load = 1'b0; bk_save = 1'b0; bk_abort = 1'b0;
    ram_mask_file = 8'h00; has_rtc = 1'b0;
    sd_ack = 1'b1; sd_buff_wr = 1'b1;
    sd_buff_addr = 8'($urandom_range(1, 255)); sd_buff_dout = 16'($urandom_range(1, 65535));
    repeat (3) @(negedge clk_sys);
    check_all_zero("reset");
    sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_addr = 8'h00; sd_buff_dout = 16'h0;
    @(posedge clk_sys); #1 reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Save of four RAM sectors.
    run_transfer(1'b1, 3, 1'b0, 256);

    // Load of sixteen RAM sectors plus the RTC sector.
    run_transfer(1'b0, 15, 1'b1, 256);
    check_images("load_image");
    check("rtc_last", 32'(rtc_mem[0]), 32'(252 ^ 16));

    // Simultaneous edges run as a load; a save edge while busy is dropped.
    ram_mask_file = 8'h00; has_rtc = 1'b0;
    d0 = done_cnt;
    @(posedge clk_sys); #1 bk_load = 1'b1; bk_save = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("both_rd", 32'({sd_rd, sd_wr}), 32'd2);
    bk_save = 1'b0;
    @(negedge clk_sys);
    bk_save = 1'b1;
    serve_sector(0, 1'b0, 0, 1'b0, 4, 1'b1);
    repeat (6) @(negedge clk_sys);
    check("no_requeue", 32'({bk_busy, sd_rd, sd_wr}), 32'd0);
    check("both_done", 32'(done_cnt - d0), 32'd1);
    bk_load = 1'b0; bk_save = 1'b0;
    check_images("both_image");

    // Abort during the third sector of a load.
    d0 = done_cnt;
    start_transfer(1'b0, 7, 1'b0);
    serve_sector(0, 1'b0, 7, 1'b0, 8, 1'b0);
    serve_sector(1, 1'b0, 7, 1'b0, 8, 1'b0);
    wait_req();
    check("abort_lba", sd_lba, 32'd2);
    @(posedge clk_sys); #1 sd_ack = 1'b1;
    @(posedge clk_sys); #1;
    for (int a = 0; a < 3; a++) begin
      sd_buff_addr = 8'(a); sd_buff_dout = 16'(a ^ 2); sd_buff_wr = 1'b1;
      ref_ram[{9'd2, 8'(a)}] = 16'(a ^ 2);
      @(posedge clk_sys); #1;
    end
    wc = wr_cnt;
    bk_abort = 1'b1; sd_buff_addr = 8'd3; sd_buff_dout = 16'hBEEF;
    @(negedge clk_sys);
    check("abort_gate", 32'({bk_wr, bk_rtc_wr}), 32'd0);
    @(negedge clk_sys);
    check("abort_idle", 32'({bk_busy, sd_rd, sd_wr, bk_wr}), 32'd0);
    @(posedge clk_sys); #1 bk_abort = 1'b0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_no_wr", 32'(wr_cnt - wc), 32'd0);
    check_images("abort_image");

    // Reset in the middle of the second sector of a save.
    start_transfer(1'b1, 3, 1'b0);
    serve_sector(0, 1'b1, 3, 1'b0, 4, 1'b0);
    wait_req();
    @(posedge clk_sys); #1 sd_ack = 1'b1;
    @(posedge clk_sys); #1 sd_buff_addr = 8'd5; sd_buff_dout = 16'h1234;
    @(posedge clk_sys); #2 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    @(posedge clk_sys); #1 sd_ack = 1'b0; sd_buff_addr = 8'h00; sd_buff_dout = 16'h0;
    @(posedge clk_sys); #1 reset_n = 1'b1;
    run_transfer(1'b1, 0, 1'b0, 8);

    // Largest image: 256 RAM sectors plus the RTC sector at LBA 256.
    run_transfer(1'b0, 255, 1'b1, 1);
    check_images("full_image");

    // Randomized small transfers.
    for (int t = 0; t < 4; t++) begin
      bit sv;
      sv = 1'($urandom_range(0, 1));
      run_transfer(sv, $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom_range(1, 8));
      if (!sv) check_images("rand_image");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
